// File: rtl/dma_write_engine.sv
// DMA destination engine: pops words from the channel FIFO, whose read port is registered,
// and writes them to consecutive addresses over a req/ack bus that allows one outstanding write.
module dma_write_engine #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 32,
   parameter int LENWIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDRWIDTH-1:0] dst_addr,
   input  logic [LENWIDTH-1:0]  xfer_len,
   output logic                 busy,
   output logic                 done,
   output logic [LENWIDTH-1:0]  words_done,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [DATAWIDTH-1:0] fifo_dout,
   output logic                 mem_req,
   output logic [ADDRWIDTH-1:0] mem_addr,
   output logic [DATAWIDTH-1:0] mem_wdata,
   input  logic                 mem_ack
);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, DONE} state_t;

   localparam logic [ADDRWIDTH-1:0] ADDR_STEP = ADDRWIDTH'(DATAWIDTH / 8);

   state_t              state;
   logic [LENWIDTH-1:0] remaining;

   // NOTE: the read strobe is combinational so that the FIFO sees it in the same FETCH cycle;
   // it is a pure function of state and the empty flag, so no latch can form.
   assign fifo_rd_en = (state == FETCH) && !fifo_empty;

   // NOTE: every register here, the datapath included, has a reset value, because the outputs
   // driven from them must read as 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         words_done <= '0;
         remaining  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mem_addr   <= dst_addr;
                  remaining  <= xfer_len;
                  words_done <= '0;
                  busy       <= 1'b1;
                  if (xfer_len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (!fifo_empty) state <= LOAD;
            end
            LOAD: begin
               // The FIFO data appears one cycle after the strobe, so it is captured here.
               mem_wdata <= fifo_dout;
               mem_req   <= 1'b1;
               state     <= WRITE;
            end
            WRITE: begin
               if (mem_ack) begin
                  mem_req    <= 1'b0;
                  mem_addr   <= mem_addr + ADDR_STEP;
                  remaining  <= remaining - 1'b1;
                  words_done <= words_done + 1'b1;
                  if (remaining == LENWIDTH'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_write_engine.sv
// Bench for dma_write_engine: a FIFO model with a registered read port, a memory-side
// scoreboard, table-driven transfers, hand-written corner-case sequences and randomized transfers.
module tb_dma_write_engine;

   logic        clk = 1'b0;
   logic        rst, start, busy, done, fifo_empty, fifo_rd_en, mem_req, mem_ack;
   logic [31:0] dst_addr, fifo_dout, mem_addr, mem_wdata;
   logic [15:0] xfer_len, words_done;

   dma_write_engine dut (
      .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr), .xfer_len(xfer_len),
      .busy(busy), .done(done), .words_done(words_done), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   // FIFO model
   logic [31:0] fmem [0:255];
   int          wr_ptr, rd_ptr;
   assign fifo_empty = (wr_ptr == rd_ptr);

   typedef struct { int cyc; logic [31:0] data; } push_t;
   push_t       sched[$];
   logic [31:0] exp_data[$];

   // Observation logs
   logic [31:0] w_addr[$], w_data[$];
   int          rd_cyc[$], done_cyc_q[$];
   int          cyc, n_req, n_req_cycles, n_busy, req_age, ack_mode, restart_cyc;
   logic        req_d, stable_ok;
   logic [31:0] req_addr0, req_data0;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct { logic [31:0] addr; int len; int exp_done; } vec_t;
   vec_t tbl[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] d);
      fmem[wr_ptr % 256] = d;
      wr_ptr++;
      exp_data.push_back(d);
   endtask

   // One clock: sample at the falling edge, then return just after the rising edge.
   task automatic step();
      logic pop;
      @(negedge clk);
      pop = fifo_rd_en;
      if (pop) rd_cyc.push_back(cyc);
      if (mem_req && mem_ack && !rst) begin
         w_addr.push_back(mem_addr);
         w_data.push_back(mem_wdata);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (busy) n_busy++;
      if (mem_req) begin
         n_req_cycles++;
         req_age++;
         if (!req_d) begin
            n_req++;
            req_addr0 = mem_addr;
            req_data0 = mem_wdata;
         end else if (mem_addr != req_addr0 || mem_wdata != req_data0) begin
            stable_ok = 1'b0;
         end
      end else begin
         req_age = 0;
      end
      req_d = mem_req;
      @(posedge clk);
      #1;
      if (pop) begin
         fifo_dout = fmem[rd_ptr % 256];
         rd_ptr++;
      end
      cyc++;
   endtask

   task automatic drive_cycle_inputs();
      while (sched.size() > 0 && sched[0].cyc <= cyc) push_word(sched.pop_front().data);
      case (ack_mode)
         0:       mem_ack = 1'b1;
         1:       mem_ack = 1'($urandom_range(0, 1));
         default: mem_ack = mem_req && (req_age >= 5);
      endcase
   endtask

   task automatic clear_logs();
      w_addr.delete(); w_data.delete(); rd_cyc.delete(); done_cyc_q.delete();
      cyc = 0; n_req = 0; n_req_cycles = 0; n_busy = 0; req_age = 0;
      req_d = 1'b0; stable_ok = 1'b1;
   endtask

   // Start a transfer in cycle 0 and run until done is seen or the budget runs out.
   task automatic run(input logic [31:0] addr, input int len, input int budget);
      clear_logs();
      dst_addr = addr;
      xfer_len = 16'(len);
      start    = 1'b1;
      drive_cycle_inputs();
      step();
      while (done_cyc_q.size() == 0 && cyc < budget) begin
         start    = (cyc == restart_cyc);
         dst_addr = 32'hDEAD_0000;
         xfer_len = 16'd9;
         drive_cycle_inputs();
         step();
      end
      start = 1'b0;
   endtask

   // Reference: word k lands at addr + 4k (32-bit wrap) carrying the k-th word pushed.
   task automatic check_xfer(input logic [31:0] addr, input int len);
      logic [31:0] ea, ed;
      check("n_writes", w_addr.size(), len);
      for (int k = 0; k < len; k++) begin
         ea = addr + 32'(4 * k);
         ed = exp_data.pop_front();
         if (k < w_addr.size()) begin
            check($sformatf("wr%0d_addr", k), w_addr[k], ea);
            check($sformatf("wr%0d_data", k), w_data[k], ed);
         end
      end
      check("n_reads", rd_cyc.size(), len);
      check("n_req", n_req, len);
      check("done_pulses", done_cyc_q.size(), 1);
      check("words_done", words_done, len);
      check("busy_after", busy, 0);
      check("done_after", done, 0);
   endtask

   initial begin
      tbl[0] = '{32'h0000_1000, 4, 13};
      tbl[1] = '{32'h0000_2000, 0, 1};
      tbl[2] = '{32'hFFFF_FFFC, 2, 7};
      tbl[3] = '{32'h0000_0040, 1, 4};

      rst = 1'b1; start = 1'b0; mem_ack = 1'b0; fifo_dout = '0;
      dst_addr = '0; xfer_len = '0; wr_ptr = 0; rd_ptr = 0;
      ack_mode = 0; restart_cyc = -1;
      clear_logs();
      step();
      step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_words_done", words_done, 0);
      rst = 1'b0;
      step();

      // Best-case transfers: FIFO preloaded, ack tied high.
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < tbl[i].len; k++) push_word(32'hA0 + 32'(k));
         ack_mode = 0;
         run(tbl[i].addr, tbl[i].len, 100);
         if (done_cyc_q.size() > 0) check($sformatf("v%0d_done_cyc", i), done_cyc_q[0], tbl[i].exp_done);
         check($sformatf("v%0d_busy_cycles", i), n_busy, tbl[i].exp_done);
         check_xfer(tbl[i].addr, tbl[i].len);
         check($sformatf("v%0d_fifo_empty", i), fifo_empty, 1);
      end

      // FIFO starvation: words arrive in cycles 5 and 12.
      sched.push_back('{5, 32'h5151_0001});
      sched.push_back('{12, 32'h5151_0002});
      ack_mode = 0;
      run(32'h0000_3000, 2, 60);
      check("starve_rd0_cyc", rd_cyc.size() > 0 ? rd_cyc[0] : -1, 5);
      check("starve_rd1_cyc", rd_cyc.size() > 1 ? rd_cyc[1] : -1, 12);
      check("starve_done_cyc", done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, 15);
      check_xfer(32'h0000_3000, 2);

      // Ack backpressure: ack held low for the first 5 request cycles.
      push_word(32'hB0);
      ack_mode = 2;
      run(32'h0000_5000, 1, 60);
      check("bp_req_cycles", n_req_cycles, 6);
      check("bp_stable", stable_ok, 1);
      check("bp_done_cyc", done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, 9);
      check_xfer(32'h0000_5000, 1);

      // Start while busy is ignored, then a back-to-back transfer. The FIFO holds
      // more words than the first transfer asks for, so it must stop after three reads.
      for (int k = 0; k < 5; k++) push_word(32'hC0 + 32'(k));
      ack_mode = 0;
      restart_cyc = 4;
      run(32'h0000_6000, 3, 100);
      restart_cyc = -1;
      check("busy_start_done_cyc", done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, 10);
      check_xfer(32'h0000_6000, 3);
      run(32'h0000_7000, 2, 100);
      check("b2b_done_cyc", done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, 7);
      check_xfer(32'h0000_7000, 2);

      // Reset in WRITE with ack high in the same cycle.
      push_word(32'hD0);
      push_word(32'hD1);
      ack_mode = 2;
      clear_logs();
      dst_addr = 32'h0000_8000; xfer_len = 16'd2; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 10 && !mem_req; i++) begin
         drive_cycle_inputs();
         step();
      end
      check("rm_in_write", mem_req, 1);
      mem_ack = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_ack = 1'b0;
      check("rm_busy", busy, 0);
      check("rm_mem_req", mem_req, 0);
      check("rm_words_done", words_done, 0);
      check("rm_mem_addr", mem_addr, 0);
      step();
      step();
      check("rm_no_done", done_cyc_q.size(), 0);
      check("rm_no_write", w_addr.size(), 0);
      check("rm_one_read", rd_cyc.size(), 1);
      rd_ptr = wr_ptr;
      exp_data.delete();

      // Randomized transfers with random ack delays.
      ack_mode = 1;
      for (int t = 0; t < 25; t++) begin
         int          len;
         logic [31:0] addr;
         len  = $urandom_range(0, 6);
         addr = $urandom;
         for (int k = 0; k < len; k++) push_word($urandom);
         run(addr, len, 400);
         check_xfer(addr, len);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dma_write_engine.md
# dma_write_engine

Destination-side engine of the DMA channel. It drains words from the channel's 32-bit data FIFO, which has a registered read port, and writes them to sequential destination addresses over a single-outstanding req/ack memory-write interface. A transfer is armed by a one-cycle `start` carrying destination address and word count. The engine signals completion with `done` and frees the channel for the next descriptor.

## Interface
- `DATAWIDTH`, default 32: FIFO and memory data width.
- `ADDRWIDTH`, default 32: byte address width.
- `LENWIDTH`, default 16: transfer length width, in words.
- `clk`, input, 1: single clock; all logic on posedge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: one-cycle pulse that arms a transfer; accepted only in IDLE.
- `dst_addr`, input, ADDRWIDTH: first destination byte address; sampled on an accepted `start`.
- `xfer_len`, input, LENWIDTH: number of words to move; sampled on an accepted `start`.
- `busy`, output, 1: high in every state other than IDLE.
- `done`, output, 1: one-cycle pulse when the transfer completes.
- `words_done`, output, LENWIDTH: words written in the current or last transfer.
- `fifo_empty`, input, 1: FIFO empty flag.
- `fifo_rd_en`, output, 1: FIFO read strobe (combinational).
- `fifo_dout`, input, DATAWIDTH: FIFO read data, valid the cycle after a read strobe is sampled.
- `mem_req`, output, 1: write request (registered).
- `mem_addr`, output, ADDRWIDTH: write byte address.
- `mem_wdata`, output, DATAWIDTH: write data.
- `mem_ack`, input, 1: write accepted; sampled only while `mem_req` is high.

## Operation
- **States:** IDLE, FETCH, LOAD, WRITE, DONE.
- **IDLE:**
  - On `start`, latch `dst_addr` into `mem_addr`, latch `xfer_len` into `remaining`, and clear `words_done`.
  - If `xfer_len` is 0, go to DONE; otherwise go to FETCH.
- **FETCH:**
  - `fifo_rd_en = !fifo_empty`; it is 0 in every other state.
  - When `fifo_empty` is 0, go to LOAD; otherwise stay in FETCH indefinitely.
- **LOAD:** `mem_wdata <= fifo_dout`; set `mem_req <= 1`; go to WRITE.
- **WRITE:**
  - Hold `mem_req`, `mem_addr` and `mem_wdata` stable until `mem_ack` is sampled high.
  - On ack:
    - `mem_req <= 0`.
    - `mem_addr <= mem_addr + DATAWIDTH/8`, modulo 2^ADDRWIDTH (wraps silently).
    - `remaining <= remaining - 1`; `words_done <= words_done + 1`.
    - If `remaining` was 1, go to DONE; otherwise go to FETCH.
- **DONE:** `done = 1` for exactly this cycle, then go to IDLE.
- **Ignored inputs:**
  - `start` is ignored whenever the state is not IDLE.
  - `mem_ack` is ignored whenever `mem_req` is low.
- **Read bound:** never more than `xfer_len` FIFO reads per transfer, and at most one read per word.
- **Reset values:** IDLE; `busy`, `done`, `fifo_rd_en` and `mem_req` are 0; `mem_addr`, `mem_wdata` and `words_done` are 0.
- **Reset mid-transfer:** `rst` wins over everything, including an ack in the same cycle.
  - The next cycle is IDLE with the reset values above.
  - `mem_req` drops on that edge.
  - Any word in flight is abandoned; the FIFO is not touched.

## Timing
- **FIFO read latency:** `fifo_rd_en` is high in FETCH cycle N; `fifo_dout` is captured at the end of cycle N+1 (LOAD).
- **Request timing:** `mem_req` rises at the start of cycle N+2.
- **Per-word cost:** minimum 3 cycles (FETCH, LOAD, WRITE with same-cycle ack). Each cycle of FIFO empty or ack delay adds one cycle.
- **Best-case transfer:** `start` in cycle 0, FIFO never empty, ack always immediate.
  - Word k request occupies cycle 3+3k.
  - `done` pulses in cycle 3·len+1; `busy` is high in cycles 1 through 3·len+1.
- **Zero-length transfer:** `start` in cycle 0 gives `done` in cycle 1 and IDLE in cycle 2; no FIFO read, no request.
- **Back-to-back transfers:** a `start` in the cycle after `done` (IDLE) is accepted.
- **Registered outputs:** `busy`, `done` and `words_done` are derived from registered state (glitch-free). `fifo_rd_en` is the only combinational output.

## Test plan
- **Basic transfer:**
  - Stimulus: preload the FIFO with 0xA0..0xA3; start with `dst_addr=0x1000`, `xfer_len=4`; `mem_ack` tied high.
  - Response: writes (0x1000,0xA0), (0x1004,0xA1), (0x1008,0xA2), (0x100C,0xA3); `done` in cycle 13; `words_done=4`; FIFO empty.
- **FIFO starvation:**
  - Stimulus: start with `xfer_len=2` and the FIFO empty; push one word in cycle 5 and one in cycle 12.
  - Response: `fifo_rd_en` only after each push; exactly 2 reads; 2 writes; `done` after the second ack.
- **Ack backpressure:**
  - Stimulus: `xfer_len=1`; hold `mem_ack` low for 5 cycles after `mem_req` rises.
  - Response: `mem_req`, `mem_addr` and `mem_wdata` constant for 6 cycles; `done` the cycle after the ack.
- **Zero length and address wrap:**
  - Zero length: `xfer_len=0` gives `done` in cycle 1, no read, no request.
  - Wrap: `dst_addr=0xFFFFFFFC`, `xfer_len=2` gives writes at 0xFFFFFFFC then 0x00000000.
- **Start while busy, then back-to-back:**
  - Start while busy: a second `start` mid-transfer is ignored; `mem_addr` sequence unchanged.
  - Back-to-back: a new `start` the cycle after `done` is accepted.
- **Reset mid-operation:**
  - Stimulus: assert `rst` for 1 cycle while in WRITE with `mem_ack` high.
  - Response: next cycle IDLE, `mem_req=0`, `words_done=0`, `busy=0`, no `done` pulse.
